// File: rtl/fetch_pkg.sv
// Shared types and constants for the stage-1 fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    FLUSH
  } fetch_state_e;

  typedef enum logic [1:0] {
    NONE,
    TRAP,
    MISPRED,
    FENCE
  } redir_cause_e;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/redir_arb.sv
// Fixed-priority selection among same-cycle redirect pulses: trap > mispred > fence.i.
module redir_arb
  import fetch_pkg::*;
(
  input  logic         trap_i,
  input  logic [31:0]  trap_pc_i,
  input  logic         mispred_i,
  input  logic [31:0]  tp_addr_i,
  input  logic         fence_i_i,
  input  logic [31:0]  fence_pc_i,
  output logic         redir_valid_o,
  output redir_cause_e redir_cause_o,
  output logic [31:0]  redir_pc_o
);

  always_comb begin
    redir_valid_o = 1'b1;
    redir_cause_o = NONE;
    redir_pc_o    = '0;
    if (trap_i) begin
      redir_cause_o = TRAP;
      redir_pc_o    = trap_pc_i;
    end else if (mispred_i) begin
      redir_cause_o = MISPRED;
      redir_pc_o    = tp_addr_i;
    end else if (fence_i_i) begin
      redir_cause_o = FENCE;
      redir_pc_o    = fence_pc_i;
    end else begin
      redir_valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem request at a time and hands
// fetched words to decode. Redirects squash in-flight responses.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic        mispred_i,
  input  logic [31:0] tp_addr_i,
  input  logic        fence_i_i,
  input  logic [31:0] fence_pc_i,
  input  logic        bp_taken_i,
  input  logic [31:0] bp_target_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        icache_flush_o,
  input  logic        icache_flush_done_i,
  output logic        if_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] if_addr_o,
  output logic [31:0] if_instr_o,
  output logic        if_pred_taken_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  if_addr_q, if_addr_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic         pred_q, pred_d;
  logic         squash_q, squash_d;
  logic         fence_pend_q, fence_pend_d;
  logic         live_q;

  logic         redir_valid;
  redir_cause_e redir_cause;
  logic [31:0]  redir_pc;
  logic         is_fence;

  redir_arb u_redir_arb (
    .trap_i        (trap_i),
    .trap_pc_i     (trap_pc_i),
    .mispred_i     (mispred_i),
    .tp_addr_i     (tp_addr_i),
    .fence_i_i     (fence_i_i),
    .fence_pc_i    (fence_pc_i),
    .redir_valid_o (redir_valid),
    .redir_cause_o (redir_cause),
    .redir_pc_o    (redir_pc)
  );

  assign is_fence = redir_valid && (redir_cause == FENCE);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_addr_d    = if_addr_q;
    if_instr_d   = if_instr_q;
    pred_d       = pred_q;
    squash_d     = squash_q;
    fence_pend_d = fence_pend_q;

    if (redir_valid) pc_d = redir_pc;
    if (is_fence) fence_pend_d = 1'b1;

    unique case (state_q)
      FETCH: begin
        if (live_q && imem_req_ready_i) begin
          state_d = WAIT;
          // Accepted with the old address: its response must be dropped.
          if (redir_valid) squash_d = 1'b1;
        end else if (fence_pend_d) begin
          state_d = FLUSH;
        end
      end
      WAIT: begin
        if (imem_rsp_valid_i) begin
          if (squash_q || redir_valid) begin
            squash_d = 1'b0;
            state_d  = fence_pend_d ? FLUSH : FETCH;
          end else begin
            if_instr_d = imem_rsp_data_i;
            if_addr_d  = pc_q;
            state_d    = HOLD;
          end
        end else if (redir_valid) begin
          squash_d = 1'b1;
        end
      end
      HOLD: begin
        if (redir_valid) begin
          state_d = fence_pend_d ? FLUSH : FETCH;
        end else if (id_ready_i) begin
          pc_d    = bp_taken_i ? bp_target_i : if_addr_q + PC_INC;
          pred_d  = bp_taken_i;
          state_d = FETCH;
        end
      end
      FLUSH: begin
        // A fresh fence.i arriving with done keeps the flush going.
        if (icache_flush_done_i && !is_fence) begin
          fence_pend_d = 1'b0;
          state_d      = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      if_addr_q    <= '0;
      if_instr_q   <= '0;
      pred_q       <= 1'b0;
      squash_q     <= 1'b0;
      fence_pend_q <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_addr_q    <= if_addr_d;
      if_instr_q   <= if_instr_d;
      pred_q       <= pred_d;
      squash_q     <= squash_d;
      fence_pend_q <= fence_pend_d;
      live_q       <= 1'b1;
    end
  end

  // live_q keeps the request low through reset and lets it rise one cycle later.
  assign imem_req_valid_o = live_q && (state_q == FETCH);
  assign imem_req_addr_o  = pc_q;
  assign icache_flush_o   = (state_q == FLUSH);
  assign if_valid_o       = (state_q == HOLD);
  assign if_addr_o        = if_addr_q;
  assign if_instr_o       = if_instr_q;
  assign if_pred_taken_o  = pred_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a one-cycle memory model and request/handoff scoreboards.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap, mispred, fence_i;
  logic [31:0] trap_pc, tp_addr, fence_pc;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        icache_flush, icache_flush_done;
  logic        if_valid, id_ready;
  logic [31:0] if_addr, if_instr;
  logic        if_pred_taken;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] req_q[$];
  logic [31:0] hand_q[$];
  logic        bp_en;
  logic        acc;
  logic [31:0] acc_addr;
  logic [31:0] exp_a;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .trap_i              (trap),
    .trap_pc_i           (trap_pc),
    .mispred_i           (mispred),
    .tp_addr_i           (tp_addr),
    .fence_i_i           (fence_i),
    .fence_pc_i          (fence_pc),
    .bp_taken_i          (bp_taken),
    .bp_target_i         (bp_target),
    .imem_req_valid_o    (imem_req_valid),
    .imem_req_ready_i    (imem_req_ready),
    .imem_req_addr_o     (imem_req_addr),
    .imem_rsp_valid_i    (imem_rsp_valid),
    .imem_rsp_data_i     (imem_rsp_data),
    .icache_flush_o      (icache_flush),
    .icache_flush_done_i (icache_flush_done),
    .if_valid_o          (if_valid),
    .id_ready_i          (id_ready),
    .if_addr_o           (if_addr),
    .if_instr_o          (if_instr),
    .if_pred_taken_o     (if_pred_taken)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_accept(input logic [31:0] a);
    logic hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clk);
      hit = imem_req_valid && imem_req_ready && (imem_req_addr == a);
    end
    chk($sformatf("accept_%0h", a), {31'd0, hit}, 32'd1);
  endtask

  task automatic wait_hold(input logic [31:0] a);
    logic hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clk);
      hit = if_valid && (if_addr == a);
    end
    chk($sformatf("hold_%0h", a), {31'd0, hit}, 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    trap = 1'b0; mispred = 1'b0; fence_i = 1'b0;
    trap_pc = '0; tp_addr = '0; fence_pc = '0;
    bp_taken = 1'b0; bp_target = 32'h80; bp_en = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    icache_flush_done = 1'b0; id_ready = 1'b1;
    req_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h200};
    hand_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

    fork
      // Memory: answers every accepted request one cycle later; predictor model.
      forever begin
        @(negedge clk);
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        @(posedge clk);
        #1;
        imem_rsp_valid = acc;
        imem_rsp_data  = acc ? mem_word(acc_addr) : 32'h0;
        bp_taken       = bp_en && (if_addr == 32'h10);
      end
      // Scoreboard: accepted requests and decode handoffs, in order.
      forever begin
        @(negedge clk);
        if (rst && imem_req_valid && imem_req_ready) begin
          if (req_q.size() == 0) chk("req_unexpected", imem_req_addr, 32'hFFFF_FFFF);
          else begin
            exp_a = req_q.pop_front();
            chk("req_addr", imem_req_addr, exp_a);
          end
        end
        if (rst && if_valid && id_ready && !trap && !mispred && !fence_i) begin
          if (hand_q.size() == 0) chk("hand_unexpected", if_addr, 32'hFFFF_FFFF);
          else begin
            exp_a = hand_q.pop_front();
            chk("hand_addr", if_addr, exp_a);
            chk("hand_instr", if_instr, mem_word(exp_a));
          end
        end
      end
    join_none

    #2;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_addr", if_addr, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_pred", {31'd0, if_pred_taken}, 32'd0);
    chk("rst_flush", {31'd0, icache_flush}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Sequential fetch and minimum latency.
    wait_accept(32'h0);
    @(negedge clk);
    chk("lat_wait_if_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    chk("lat_hold_if_valid", {31'd0, if_valid}, 32'd1);

    // Mispredict while 0x14 is in flight.
    wait_accept(32'h14);
    step();
    mispred = 1'b1; tp_addr = 32'h200;
    step();
    mispred = 1'b0; id_ready = 1'b0; bp_en = 1'b1;

    // Trap in HOLD with id_ready also high.
    wait_hold(32'h200);
    chk("hold_instr_200", if_instr, mem_word(32'h200));
    req_q.push_back(32'h10);  hand_q.push_back(32'h10);
    req_q.push_back(32'h80);  hand_q.push_back(32'h80);
    step();
    trap = 1'b1; trap_pc = 32'h10; id_ready = 1'b1;
    step();
    trap = 1'b0;
    @(negedge clk);
    chk("hold_redir_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("hold_redir_addr", imem_req_addr, 32'h10);
    chk("hold_redir_if_valid", {31'd0, if_valid}, 32'd0);

    // Predicted-taken handoff at 0x10.
    wait_accept(32'h80);
    chk("pred_taken_set", {31'd0, if_pred_taken}, 32'd1);
    wait_hold(32'h80);
    step();
    imem_req_ready = 1'b0;

    // Stalled request keeps its address; redirects retarget it.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stall_addr", imem_req_addr, 32'h84);
    end
    chk("pred_taken_clr", {31'd0, if_pred_taken}, 32'd0);
    step();
    mispred = 1'b1; tp_addr = 32'h500;
    step();
    mispred = 1'b0;
    @(negedge clk);
    chk("retarget_500", imem_req_addr, 32'h500);
    step();
    trap = 1'b1; trap_pc = 32'h100; mispred = 1'b1; tp_addr = 32'h300;
    step();
    trap = 1'b0; mispred = 1'b0;
    @(negedge clk);
    chk("trap_over_mispred", imem_req_addr, 32'h100);
    req_q.push_back(32'h100); hand_q.push_back(32'h100);
    req_q.push_back(32'h104);
    req_q.push_back(32'h40);  hand_q.push_back(32'h40);
    step();
    imem_req_ready = 1'b1;

    // fence.i while 0x104 is in flight.
    wait_accept(32'h104);
    step();
    fence_i = 1'b1; fence_pc = 32'h40;
    step();
    fence_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_high", {31'd0, icache_flush}, 32'd1);
      chk("flush_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    step();
    icache_flush_done = 1'b1;
    step();
    icache_flush_done = 1'b0;
    @(negedge clk);
    chk("flush_low", {31'd0, icache_flush}, 32'd0);
    chk("refetch_addr", imem_req_addr, 32'h40);

    wait_hold(32'h40);
    step();
    imem_req_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("req_q_drained", req_q.size(), 32'd0);
    chk("hand_q_drained", hand_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for stage 1. It owns the program counter, issues one instruction-memory request at a time over a valid/ready handshake, and hands each fetched instruction to decode. It selects the next PC from trap, mispredict, fence-flush, branch-prediction and sequential sources. Redirects that arrive mid-transaction squash the in-flight response instead of corrupting the request handshake.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- trap  in  1  trap redirect pulse (highest priority)
- trap_pc  in  32  trap vector
- mispred  in  1  branch-resolution mispredict pulse
- tp_addr  in  32  corrected target
- fence_i  in  1  fence.i pulse: flush I-cache, then refetch
- fence_pc  in  32  refetch address after flush
- bp_taken  in  1  predictor verdict for if_addr (valid in HOLD)
- bp_target  in  32  predicted target for if_addr
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  request address
- imem_rsp_valid  in  1  response valid, one cycle, at most one per accepted request
- imem_rsp_data  in  32  instruction word
- icache_flush  out  1  level flush request
- icache_flush_done  in  1  flush complete pulse
- if_valid  out  1  instruction valid to decode
- id_ready  in  1  decode accepts
- if_addr  out  32  PC of if_instr
- if_instr  out  32  instruction
- if_pred_taken  out  1  bp_taken captured at handoff

## Operation
- States: FETCH, WAIT, HOLD, FLUSH. Reset state is FETCH with pc=RESET_PC.
- FETCH: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready, go to WAIT.
- WAIT: on imem_rsp_valid:
  - If squash=0: capture data into if_instr and pc into if_addr, go to HOLD.
  - If squash=1: discard the response, clear squash, go to FLUSH if fence_pend, else go to FETCH.
- HOLD: if_valid=1. On id_ready:
  - pc ← bp_taken ? bp_target : if_addr+4 (mod 2^32).
  - if_pred_taken ← bp_taken.
  - Go to FETCH.
- FLUSH: icache_flush=1. On icache_flush_done, clear fence_pend, go to FETCH at pc.
- Redirect priority in a single cycle: trap > mispred > fence_i. Lower-priority pulses in the same cycle are dropped.
- A redirect sets pc ← its target. Its effect depends on the current state:
  - In FETCH, or in WAIT without a same-cycle response: set squash=1. For FETCH without a same-cycle accept, the request is instead retargeted next cycle.
  - In HOLD: if_valid drops next cycle; go to FETCH (or FLUSH for a fence). id_ready in the same cycle is ignored.
- The request address is stable while imem_req_valid=1 and imem_req_ready=0. A redirect in FETCH updates imem_req_addr only when the request was not accepted in that cycle. If it was accepted in that cycle, the transaction is squashed.
- fence_i sets fence_pend. FLUSH is entered only once no response is outstanding.
- trap or mispred during FLUSH updates pc only; the flush still completes.
- A response arriving in the same cycle as a redirect is treated as stale (discarded).

## Timing
- Reset values: imem_req_valid=0 during reset, imem_req_addr=RESET_PC, if_valid=0, if_addr=0, if_instr=0, if_pred_taken=0, icache_flush=0. imem_req_valid rises in the first cycle after rst deasserts.
- All outputs are registered or decoded from state only; there is no combinational input→output path.
- Minimum 3 cycles per instruction: accept at edge N, response at N+1, if_valid from N+2.
- Redirect in HOLD at edge N: request at the new pc from cycle N+1.
- Reset mid-transaction returns to FETCH at RESET_PC and clears squash and fence_pend.

## Structure
- fetch_pkg holds:
  - fetch_state_e {FETCH, WAIT, HOLD, FLUSH}
  - redir_cause_e {NONE, TRAP, MISPRED, FENCE}
  - PC_INC=32'd4
- Sub-module redir_arb: priority encoder over the three redirect pulses. Outputs redir_valid, redir_cause and redir_pc. Purely combinational; the pending flags live in fetch_ctrl.

## Test plan
- Reset, memory always ready, response after 1 cycle, id_ready=1, bp_taken=0 → requests at 0, 4, 8 … with if_valid every 3rd cycle.
- In HOLD at if_addr=0x10, bp_taken=1, bp_target=0x80 → next imem_req_addr=0x80, if_pred_taken=1.
- mispred with tp_addr=0x200 one cycle after accepting 0x14 → response for 0x14 discarded (if_valid stays 0), next request at 0x200.
- trap (trap_pc=0x100) and mispred (tp_addr=0x300) in the same cycle → next request 0x100.
- fence_i (fence_pc=0x40) in WAIT → response discarded, icache_flush high until done, then request at 0x40.
- imem_req_ready held 0 for 5 cycles → imem_req_addr stable; then a mispred to 0x500 changes the address the next cycle.
